// File: rtl/div_ctrl.sv
// Multi-cycle radix-2 restoring divider sequencer for DIV/DIVU; returns {rem, quot}.
// Optional DIV_EARLY_OUT_EN: skip the shift loop when |a| < |b| (quot=0, rem=a).
module div_ctrl #(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  div_start,
   input  logic                  div_signed,
   input  logic                  annul,
   input  logic [DATA_W-1:0]     opdata_a,
   input  logic [DATA_W-1:0]     opdata_b,
   output logic [2*DATA_W-1:0]   result,
   output logic                  ready,
   output logic                  stall_req
);

   localparam int CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_DIVZERO,
      S_BUSY,
      S_DONE
   } state_t;

   state_t              r_state;
   state_t              w_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W-1:0]   r_rem;
   logic [DATA_W-1:0]   r_quo;
   logic [DATA_W-1:0]   r_b;
   logic                r_neg_q;
   logic                r_neg_r;
   logic [2*DATA_W-1:0] r_result;
   logic                r_ready;

   logic [DATA_W-1:0]   w_abs_a;
   logic [DATA_W-1:0]   w_abs_b;
   logic                w_b_zero;
   logic                w_early;
   logic [DATA_W:0]     w_rem_sh;
   logic                w_ge;
   logic [DATA_W-1:0]   w_rem_sub;
   logic                w_last;
   logic [DATA_W-1:0]   w_quo_fix;
   logic [DATA_W-1:0]   w_rem_fix;

   assign w_abs_a  = (div_signed && opdata_a[DATA_W-1]) ? -opdata_a : opdata_a;
   assign w_abs_b  = (div_signed && opdata_b[DATA_W-1]) ? -opdata_b : opdata_b;
   assign w_b_zero = (opdata_b == '0);

`ifdef DIV_EARLY_OUT_EN
   assign w_early  = ~w_b_zero & (w_abs_a < w_abs_b);
`else
   assign w_early  = 1'b0;
`endif

   // Partial remainder is one bit wider than the divisor so the compare never truncates;
   // the difference is always < |b|, so its low DATA_W bits are exact.
   assign w_rem_sh  = {r_rem, r_quo[DATA_W-1]};
   assign w_ge      = (w_rem_sh >= {1'b0, r_b});
   assign w_rem_sub = w_rem_sh[DATA_W-1:0] - r_b;
   assign w_last    = (r_cnt == CNT_W'(DATA_W - 1));

   assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
   assign w_rem_fix = r_neg_r ? -r_rem : r_rem;

   assign result    = r_result;
   assign ready     = r_ready;
   assign stall_req = div_start & ~r_ready & ~annul;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_next;
   end

   // NOTE: w_next gets its default before any branch, so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      if (annul) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (div_start) begin
                  if (w_b_zero)     w_next = S_DIVZERO;
                  else if (w_early) w_next = S_DONE;
                  else              w_next = S_BUSY;
               end
            end
            S_DIVZERO: w_next = S_DONE;
            S_BUSY:    if (w_last) w_next = S_DONE;
            S_DONE:    if (r_ready && !div_start) w_next = S_IDLE;
            default:   w_next = S_IDLE;
         endcase
      end
   end

   // NOTE: operand and result registers are reset so result reads 0 immediately after resetn falls.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_b      <= '0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
         r_ready  <= 1'b0;
      end else if (annul) begin
         r_ready  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_ready <= 1'b0;
               if (div_start) begin
                  r_b     <= w_abs_b;
                  r_neg_q <= div_signed & (opdata_a[DATA_W-1] ^ opdata_b[DATA_W-1]);
                  r_neg_r <= div_signed & opdata_a[DATA_W-1];
                  r_cnt   <= '0;
                  if (w_early) begin
                     r_rem <= w_abs_a;
                     r_quo <= '0;
                  end else begin
                     r_rem <= '0;
                     r_quo <= w_abs_a;
                  end
               end
            end
            S_DIVZERO: begin
               // Zeroed quotient/remainder make the DONE sign correction yield 0 as well.
               r_result <= '0;
               r_rem    <= '0;
               r_quo    <= '0;
            end
            S_BUSY: begin
               r_rem <= w_ge ? w_rem_sub : w_rem_sh[DATA_W-1:0];
               r_quo <= {r_quo[DATA_W-2:0], w_ge};
               r_cnt <= r_cnt + CNT_W'(1);
            end
            S_DONE: begin
               if (!r_ready) begin
                  r_result <= {w_rem_fix, w_quo_fix};
                  r_ready  <= 1'b1;
               end else if (!div_start) begin
                  r_ready  <= 1'b0;
               end
            end
            default: r_ready <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: driver pushes expected {rem,quot} and latency,
// a negedge monitor pops and compares on each rising edge of ready.
module tb_div_ctrl;

   logic        clk;
   logic        resetn;
   logic        div_start;
   logic        div_signed;
   logic        annul;
   logic [31:0] opdata_a;
   logic [31:0] opdata_b;
   logic [63:0] result;
   logic        ready;
   logic        stall_req;

   div_ctrl #(.DATA_W(32)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .div_start  (div_start),
      .div_signed (div_signed),
      .annul      (annul),
      .opdata_a   (opdata_a),
      .opdata_b   (opdata_b),
      .result     (result),
      .ready      (ready),
      .stall_req  (stall_req)
   );

   typedef struct {
      logic [63:0] res;
      int          lat;
      int          t0;
   } exp_t;

   typedef struct {
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] r;
   } vec_t;

   exp_t sb_q[$];
   exp_t mon_e;
   vec_t vecs[13];
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   logic ready_d = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: one scoreboard entry per rising edge of ready.
   always @(negedge clk) begin
      if (!resetn) begin
         ready_d = 1'b0;
      end else begin
         if (ready && !ready_d) begin
            if (sb_q.size() == 0) begin
               check("unexpected_ready", 64'(ready), 64'(0));
            end else begin
               mon_e = sb_q.pop_front();
               check("result", result, mon_e.res);
               check("latency", 64'(cyc - mon_e.t0), 64'(mon_e.lat));
            end
         end
         ready_d = ready;
      end
   end

   task automatic do_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp_res);
      int          lat;
      int          t0;
      int          bad;
      int          waited;
      logic [31:0] aa;
      logic [31:0] ab;
      exp_t        e;
      aa  = (sg && a[31]) ? -a : a;
      ab  = (sg && b[31]) ? -b : b;
      lat = (b == 32'd0) ? 2 : 33;
`ifdef DIV_EARLY_OUT_EN
      if (b != 32'd0 && aa < ab) lat = 1;
`endif
      @(negedge clk);
      div_start  = 1'b1;
      div_signed = sg;
      opdata_a   = a;
      opdata_b   = b;
      @(posedge clk);
      #1;
      t0 = cyc;
      e.res = exp_res;
      e.lat = lat;
      e.t0  = t0;
      sb_q.push_back(e);
      // Scramble operands after the start edge; the divider must ignore them.
      opdata_a   = $urandom;
      opdata_b   = $urandom;
      div_signed = ~sg;
      bad    = 0;
      waited = 0;
      while (waited < 100) begin
         @(negedge clk);
         waited++;
         if (stall_req !== ((cyc - t0) < lat)) bad++;
         if (ready) break;
      end
      check("stall_window", 64'(bad), 64'(0));
      if (!ready) begin
         check("ready_timeout", 64'(ready), 64'(1));
         sb_q.delete();
      end
      @(negedge clk);
      check("ready_held", 64'(ready), 64'(1));
      check("result_held", result, exp_res);
      div_start = 1'b0;
      @(negedge clk);
      check("ready_drop", 64'(ready), 64'(0));
   endtask

   initial begin
      vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2,          32'd14}};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF,  32'hFFFF_FFFD}};
      vecs[2]  = '{1'b1, 32'd5,          32'd0,          64'd0};
      vecs[3]  = '{1'b0, 32'd5,          32'd9,          {32'd5,          32'd0}};
      vecs[4]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'd0,          32'h8000_0000}};
      vecs[5]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0,          32'hFFFF_FFFF}};
      vecs[6]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1,          32'hFFFF_FFFD}};
      vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFE,  {32'd1,          32'd1}};
      vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE,  32'd14}};
      vecs[9]  = '{1'b0, 32'h8000_0000,  32'd3,          {32'd2,          32'h2AAA_AAAA}};
      vecs[10] = '{1'b1, 32'hFFFF_FFFB,  32'd9,          {32'hFFFF_FFFB,  32'd0}};
      vecs[11] = '{1'b0, 32'd0,          32'd0,          64'd0};
      vecs[12] = '{1'b1, 32'hFFFF_FFF9,  32'd0,          64'd0};

      resetn     = 1'b0;
      div_start  = 1'b0;
      div_signed = 1'b0;
      annul      = 1'b0;
      opdata_a   = '0;
      opdata_b   = '0;
      repeat (3) @(negedge clk);
      check("reset_ready", 64'(ready), 64'(0));
      check("reset_result", result, 64'd0);
      check("reset_stall", 64'(stall_req), 64'(0));
      resetn = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 13; i++) do_div(vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].r);

      // Annul mid-divide: no result may appear, stall is suppressed while annul is high.
      @(negedge clk);
      div_start  = 1'b1;
      div_signed = 1'b0;
      opdata_a   = 32'd100;
      opdata_b   = 32'd7;
      @(posedge clk);
      repeat (9) @(posedge clk);
      @(negedge clk);
      annul = 1'b1;
      #1;
      check("annul_stall", 64'(stall_req), 64'(0));
      @(negedge clk);
      annul     = 1'b0;
      div_start = 1'b0;
      check("annul_ready", 64'(ready), 64'(0));
      repeat (40) @(negedge clk);
      check("annul_no_ready", 64'(ready), 64'(0));
      do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

      // Asynchronous reset in the middle of a divide clears result at once.
      @(negedge clk);
      div_start  = 1'b1;
      div_signed = 1'b0;
      opdata_a   = 32'd100;
      opdata_b   = 32'd7;
      @(posedge clk);
      repeat (5) @(posedge clk);
      #2;
      resetn = 1'b0;
      #1;
      check("async_rst_ready", 64'(ready), 64'(0));
      check("async_rst_result", result, 64'd0);
      @(negedge clk);
      div_start = 1'b0;
      resetn    = 1'b1;
      repeat (40) @(negedge clk);
      check("post_rst_no_ready", 64'(ready), 64'(0));
      check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", n_checks, n_errors);
      $fatal(1);
   end

endmodule
